// File: rtl/chunked_add_sub.sv
// chunked_add_sub
//   Multi-cycle adder/subtractor. Operands are latched on an input handshake,
//   then added CHUNK bits per cycle with the inter-chunk carry held in a
//   register, so the combinational carry chain is only CHUNK bits long.
//   Zero/carry/overflow/negative flags are latched with the final chunk.
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only while idle)
//   a, b, sub             operands; sub=1 computes a + ~b + 1
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                a +/- b modulo 2^WIDTH
//   zero, carry,          result flags; carry on subtract means no borrow
//   overflow, negative
module chunked_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             negative
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
   // Low CHUNK bits set; shifted into place to splice a chunk into result.
   localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;          // b already inverted for subtract
   logic             cy_q, cy_d;        // carry between chunks
   logic [CNT_W-1:0] k_q, k_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             neg_q, neg_d;

   logic [31:0]      lo;
   logic [CHUNK-1:0] a_c, b_c;
   logic [CHUNK:0]   sum_c;
   logic [WIDTH-1:0] merged;

   // Shifts rather than indexed part-selects keep chunk selection width-clean
   // for every CHUNK, including CHUNK == WIDTH.
   assign lo     = 32'(k_q) * 32'(CHUNK);
   assign a_c    = CHUNK'(a_q >> lo);
   assign b_c    = CHUNK'(b_q >> lo);
   assign sum_c  = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cy_q};
   assign merged = (result_q & ~(MASK << lo)) | (WIDTH'(sum_c[CHUNK-1:0]) << lo);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cy_d     = cy_q;
      k_d      = k_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      neg_d    = neg_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               cy_d    = sub;           // +1 of the two's complement negate
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d = merged;
            cy_d     = sum_c[CHUNK];
            k_d      = k_q + CNT_W'(1);
            if (k_q == LAST) begin
               zero_d  = ~|merged;
               carry_d = sum_c[CHUNK];
               neg_d   = merged[WIDTH-1];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (merged[WIDTH-1] != a_q[WIDTH-1]);
               k_d     = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cy_q     <= 1'b0;
         k_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cy_q     <= cy_d;
         k_q      <= k_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         neg_q    <= neg_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: three instances (CHUNK 8, 32, 1) share operand
// and out_ready inputs; each has its own in_valid. Expected results come from
// a whole-word a +/- b model and travel through a scoreboard queue.
module tb_chunked_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  iv;
   logic [31:0] a, b;
   logic        sub, ordy;
   logic [2:0]  ird, ov, zf, cf, vf, nf;
   logic [31:0] res [3];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] r;
      logic        z, c, v, n;
   } exp_t;

   exp_t sbq[$];

   chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u_c8 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ird[0]),
      .a(a), .b(b), .sub(sub), .out_valid(ov[0]), .out_ready(ordy),
      .result(res[0]), .zero(zf[0]), .carry(cf[0]), .overflow(vf[0]), .negative(nf[0]));

   chunked_add_sub #(.WIDTH(32), .CHUNK(32)) u_c32 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ird[1]),
      .a(a), .b(b), .sub(sub), .out_valid(ov[1]), .out_ready(ordy),
      .result(res[1]), .zero(zf[1]), .carry(cf[1]), .overflow(vf[1]), .negative(nf[1]));

   chunked_add_sub #(.WIDTH(32), .CHUNK(1)) u_c1 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ird[2]),
      .a(a), .b(b), .sub(sub), .out_valid(ov[2]), .out_ready(ordy),
      .result(res[2]), .zero(zf[2]), .carry(cf[2]), .overflow(vf[2]), .negative(nf[2]));

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [32:0] full;
      exp_t e;
      full = s ? ({1'b0, x} - {1'b0, y} + 33'h1_0000_0000) : ({1'b0, x} + {1'b0, y});
      e.r = full[31:0];
      e.c = full[32];
      e.z = (full[31:0] == 32'd0);
      e.n = full[31];
      e.v = s ? ((x[31] != y[31]) && (full[31] != x[31]))
              : ((x[31] == y[31]) && (full[31] != x[31]));
      return e;
   endfunction

   function automatic int lat(input int d);
      case (d)
         0:       return 4;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   function automatic exp_t got(input int d);
      return {res[d], zf[d], cf[d], vf[d], nf[d]};
   endfunction

   task automatic test_reset();
      reset = 1'b1; iv = '0; a = '0; b = '0; sub = 1'b0; ordy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ird[d] !== 1'b1 || ov[d] !== 1'b0 || got(d) !== '0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got ready=%b valid=%b out=%h, want ready=1 valid=0 out=0",
                     d, ird[d], ov[d], got(d));
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd3, 32'h8000_0000};
      logic [31:0] tb [5] = '{32'd1,         32'd1,         32'd5, 32'd5, 32'd1};
      logic        ts [5] = '{1'b0,          1'b0,          1'b1,  1'b1,  1'b1};
      exp_t e;
      int cyc;
      ordy = 1'b1;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 5; i++) begin
            a = ta[i]; b = tb[i]; sub = ts[i];
            sbq.push_back(model(ta[i], tb[i], ts[i]));
            checks++;
            if (ird[d] !== 1'b1) begin
               errors++;
               $display("FAIL basic_ready dut%0d vec%0d: got in_ready=%b want 1", d, i, ird[d]);
            end
            iv[d] = 1'b1;
            @(posedge clk); #1;
            iv[d] = 1'b0;
            cyc = 0;
            while (ov[d] !== 1'b1 && cyc < 100) begin
               @(posedge clk); #1;
               cyc++;
            end
            e = sbq.pop_front();
            checks++;
            if (cyc != lat(d)) begin
               errors++;
               $display("FAIL basic_latency dut%0d vec%0d: got %0d cycles want %0d", d, i, cyc, lat(d));
            end
            checks++;
            if (got(d) !== e) begin
               errors++;
               $display("FAIL basic_result dut%0d vec%0d: got %h want %h", d, i, got(d), e);
            end
            @(posedge clk); #1;
            checks++;
            if (ov[d] !== 1'b0 || ird[d] !== 1'b1) begin
               errors++;
               $display("FAIL basic_release dut%0d vec%0d: got valid=%b ready=%b want valid=0 ready=1",
                        d, i, ov[d], ird[d]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int cyc;
      ordy = 1'b0;
      a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
      sbq.push_back(model(a, b, sub));
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      cyc = 0;
      while (ov[0] !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sbq.pop_front();
      checks++;
      if (got(0) !== e || ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_result: got valid=%b out=%h want valid=1 out=%h", ov[0], got(0), e);
      end
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; sub = 1'(i);
         iv[0] = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (ov[0] !== 1'b1 || ird[0] !== 1'b0 || got(0) !== e) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: got valid=%b ready=%b out=%h want 1 0 %h",
                     i, ov[0], ird[0], got(0), e);
         end
      end
      iv[0] = 1'b0;
      ordy = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ird[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got valid=%b ready=%b want 0 1", ov[0], ird[0]);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (ov[0] !== 1'b0 || ird[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_no_ghost_op: got valid=%b ready=%b want 0 1", ov[0], ird[0]);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int cyc;
      ordy = 1'b1;
      a = 32'hFFFF_FFFF; b = 32'd1; sub = 1'b0;
      iv[0] = 1'b1;
      @(posedge clk); #1;          // accepted; first RUN cycle
      iv[0] = 1'b0;
      @(posedge clk); #1;          // second RUN cycle
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (ird[0] !== 1'b1 || ov[0] !== 1'b0 || got(0) !== '0) begin
         errors++;
         $display("FAIL midreset_state: got ready=%b valid=%b out=%h want 1 0 0", ird[0], ov[0], got(0));
      end
      a = 32'd100; b = 32'd58; sub = 1'b1;
      sbq.push_back(model(a, b, sub));
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      cyc = 0;
      while (ov[0] !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sbq.pop_front();
      checks++;
      if (cyc != 4 || got(0) !== e) begin
         errors++;
         $display("FAIL midreset_next_op: got %0d cycles out=%h want 4 cycles out=%h", cyc, got(0), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_t e;
      int cyc, n;
      bit done;
      for (int d = 0; d < 3; d += 2) begin
         n = (d == 0) ? 1000 : 60;
         for (int i = 0; i < n; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            if (i % 50 == 7) b = a;
            sbq.push_back(model(a, b, sub));
            ordy = 1'($urandom_range(0, 1));
            iv[d] = 1'b1;
            @(posedge clk); #1;
            iv[d] = 1'b0;
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 300) begin
               ordy = 1'($urandom_range(0, 1));
               if (ov[d] === 1'b1 && ordy) begin
                  e = sbq.pop_front();
                  checks++;
                  if (got(d) !== e) begin
                     errors++;
                     $display("FAIL random dut%0d op%0d: got %h want %h", d, i, got(d), e);
                  end
                  done = 1'b1;
               end
               @(posedge clk); #1;
               cyc++;
            end
            if (!done) begin
               checks++;
               errors++;
               void'(sbq.pop_front());
               $display("FAIL random_timeout dut%0d op%0d: got no out_valid want one within 300 cycles", d, i);
               reset = 1'b1;
               @(posedge clk); #1;
               reset = 1'b0;
            end
         end
      end
      ordy = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
